// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The master side issues additions and the slave side (the adder) answers them.
interface serial_adder_if #(
    parameter int nrOfBits = 8
);
    logic                start;
    logic                carryIn;
    logic [nrOfBits-1:0] dataA;
    logic [nrOfBits-1:0] dataB;
    logic                busy;
    logic                done;
    logic [nrOfBits-1:0] result;
    logic                carryOut;

    modport master (
        output start, carryIn, dataA, dataB,
        input  busy, done, result, carryOut
    );

    modport slave (
        input  start, carryIn, dataA, dataB,
        output busy, done, result, carryOut
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-add per clock, LSB first, result and carry
// published together on completion and held until the next completion.
module serial_adder #(
    parameter int nrOfBits = 8
) (
    input  logic           clock,
    input  logic           reset,
    serial_adder_if.slave  bus
);
    localparam int cntWidth = (nrOfBits > 1) ? $clog2(nrOfBits) : 1;
    localparam logic [cntWidth-1:0] lastBit = cntWidth'(nrOfBits - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t              state_r,    nextState_s;
    logic [nrOfBits-1:0] opA_r,      opA_s;
    logic [nrOfBits-1:0] opB_r,      opB_s;
    logic [nrOfBits-1:0] sum_r,      sum_s;
    logic [cntWidth-1:0] cnt_r,      cnt_s;
    logic                carry_r,    carry_s;
    logic [nrOfBits-1:0] result_r,   result_s;
    logic                carryOut_r, carryOut_s;
    logic                busy_r,     busy_s;
    logic                done_r,     done_s;
    logic                sumBit_s;
    logic                carryBit_s;
    logic [nrOfBits-1:0] shifted_s;

    // Next-state and datapath update for one serial full-add step.
    always_comb begin
        nextState_s = state_r;
        opA_s       = opA_r;
        opB_s       = opB_r;
        sum_s       = sum_r;
        cnt_s       = cnt_r;
        carry_s     = carry_r;
        result_s    = result_r;
        carryOut_s  = carryOut_r;
        busy_s      = 1'b0;
        done_s      = 1'b0;

        sumBit_s   = opA_r[0] ^ opB_r[0] ^ carry_r;
        carryBit_s = majority(opA_r[0], opB_r[0], carry_r);
        // New sum bit enters at the MSB so the LSB lands at bit 0 after nrOfBits steps.
        shifted_s               = sum_r >> 1;
        shifted_s[nrOfBits-1]   = sumBit_s;

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    nextState_s = RUN;
                    opA_s       = bus.dataA;
                    opB_s       = bus.dataB;
                    carry_s     = bus.carryIn;
                    sum_s       = '0;
                    cnt_s       = '0;
                    busy_s      = 1'b1;
                end else begin
                    nextState_s = IDLE;
                end
            end
            RUN: begin
                opA_s   = opA_r >> 1;
                opB_s   = opB_r >> 1;
                sum_s   = shifted_s;
                carry_s = carryBit_s;
                cnt_s   = cnt_r + cntWidth'(1);
                if (cnt_r == lastBit) begin
                    nextState_s = FINISH;
                    result_s    = shifted_s;
                    carryOut_s  = carryBit_s;
                    done_s      = 1'b1;
                end else begin
                    nextState_s = RUN;
                    busy_s      = 1'b1;
                end
            end
            FINISH: begin
                if (bus.start) begin
                    nextState_s = RUN;
                    opA_s       = bus.dataA;
                    opB_s       = bus.dataB;
                    carry_s     = bus.carryIn;
                    sum_s       = '0;
                    cnt_s       = '0;
                    busy_s      = 1'b1;
                end else begin
                    nextState_s = IDLE;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Datapath and registered outputs; reset clears everything so an abandoned add leaves no trace.
    always_ff @(posedge clock) begin
        if (!reset) begin
            opA_r      <= '0;
            opB_r      <= '0;
            sum_r      <= '0;
            cnt_r      <= '0;
            carry_r    <= 1'b0;
            result_r   <= '0;
            carryOut_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            opA_r      <= opA_s;
            opB_r      <= opB_s;
            sum_r      <= sum_s;
            cnt_r      <= cnt_s;
            carry_r    <= carry_s;
            result_r   <= result_s;
            carryOut_r <= carryOut_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.carryOut = carryOut_r;
endmodule
